// File: rtl/change_logger_pkg.sv
// ============================================================================
// change_logger_pkg : shared types and sizing helpers for the change logger
// Revision: 1.0
// ============================================================================
`default_nettype none

package change_logger_pkg;

  localparam int LOG_DATA_W = 4;
  localparam int LOG_TS_W   = 16;
  localparam int LOG_DEPTH  = 8;

  typedef struct packed {
    logic [LOG_DATA_W-1:0] data;
    logic [LOG_TS_W-1:0]   ts;
  } log_entry_t;

  // Binary pointer width: address bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int LOG_PTR_W = ptr_w(LOG_DEPTH);

endpackage

`default_nettype wire

// File: rtl/logger_fifo.sv
// ============================================================================
// logger_fifo : synchronous FIFO of log entries, head presented combinationally
// Revision: 1.0
// ============================================================================
`default_nettype none

module logger_fifo
  import change_logger_pkg::*;
#(
  parameter type ENTRY_T = log_entry_t,
  parameter int  DEPTH   = LOG_DEPTH,
  localparam int PTR_W   = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  ENTRY_T           din,
  output ENTRY_T           dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] count
);

  localparam int AW = PTR_W - 1;

  ENTRY_T           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] w_count;
  logic             w_pop;
  logic             w_push;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign empty   = (w_count == '0);
  assign full    = (w_count == PTR_W'(DEPTH));
  assign count   = w_count;

  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/change_logger.sv
// ============================================================================
// change_logger : logs first value and every change of a sampled signal with a
// cycle timestamp. Optional input synchronizer: CHANGE_LOGGER_SYNC_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module change_logger
  import change_logger_pkg::*;
#(
  parameter int DATA_W = LOG_DATA_W,
  parameter int TS_W   = LOG_TS_W,
  parameter int DEPTH  = LOG_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DATA_W-1:0]        sample_in,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_data,
  output logic [TS_W-1:0]          rd_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } entry_t;

  logic [TS_W-1:0]   r_ts;
  logic [DATA_W-1:0] r_prev;
  logic              r_armed;
  logic              r_overflow;
  logic [DATA_W-1:0] w_sample;
  logic              w_event;
  logic              w_pop;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;
  entry_t            w_din;
  entry_t            w_head;

`ifdef CHANGE_LOGGER_SYNC_EN
  logic [DATA_W-1:0] r_sync1;
  logic [DATA_W-1:0] r_sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sample_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2;
`else
  assign w_sample = sample_in;
`endif

  assign w_event    = en && (!r_armed || (w_sample != r_prev));
  assign w_pop      = rd_valid && rd_ready;
  assign w_drop     = w_event && w_full && !w_pop;
  assign w_din.data = w_sample;
  assign w_din.ts   = r_ts;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ts       <= '0;
      r_prev     <= '0;
      r_armed    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (en) r_ts <= r_ts + 1'b1;
      // Dropping re-enable arms forces the first enabled cycle to log.
      if (!en)          r_armed <= 1'b0;
      else if (w_event) r_armed <= 1'b1;
      if (w_event) r_prev <= w_sample;
      if (w_drop)       r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;
    end
  end

  logger_fifo #(
    .ENTRY_T (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_event),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (count)
  );

  assign rd_valid = !w_empty;
  assign rd_data  = w_head.data;
  assign rd_ts    = w_head.ts;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: doc/change_logger.md
Name: change_logger

Overview:
- Synthesizable capture side for the bench's stimulus generators.
- Samples a DATA_W-bit signal on every clock edge. Logs the first value and every later change, each tagged with a free-running cycle timestamp, into a small FIFO.
- A downstream reader drains the FIFO through a valid/ready port.
- Used on-chip and in benches as the hardware counterpart of a console value monitor.

Parameters:
- DATA_W, 4: width of the sampled signal.
- TS_W, 16: timestamp counter width; the counter wraps modulo 2^TS_W.
- DEPTH, 8: FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- en, in, 1: capture enable.
- sample_in, in, DATA_W: signal being monitored.
- rd_valid, out, 1: FIFO head entry is available.
- rd_ready, in, 1: reader accepts the head entry.
- rd_data, out, DATA_W: value in the head entry.
- rd_ts, out, TS_W: timestamp of the head entry.
- count, out, $clog2(DEPTH)+1: current number of FIFO entries.
- overflow, out, 1: sticky flag; a logged event was dropped.
- clr_ovf, in, 1: clears overflow.

Behaviour:
- Reset (rst=0), asynchronous:
  - ts_q=0, prev_q=0, armed=0.
  - FIFO emptied; count=0, rd_valid=0.
  - rd_data=0, rd_ts=0, overflow=0.
- Timestamp:
  - ts_q increments by 1 on every rising edge where en=1, wrapping 2^TS_W-1 -> 0.
  - ts_q holds while en=0.
- Capture condition at a rising edge with en=1: event = !armed || (sample_in != prev_q).
  - On an event: push {sample_in, ts_q (pre-increment value)}, set prev_q=sample_in, set armed=1.
  - en=0 clears armed, so the first enabled cycle after re-enable always logs.
- Latency: an entry captured at edge N is visible on rd_valid/rd_data/rd_ts immediately after edge N. The read port is driven combinationally from the FIFO head register, with no extra cycle.
- Read handshake:
  - A pop occurs at an edge where rd_valid && rd_ready.
  - rd_data/rd_ts must stay stable while rd_valid=1 && rd_ready=0.
  - rd_data/rd_ts read 0 when empty.
- FIFO:
  - Binary read/write pointers, each with one wrap bit.
  - count = wr_ptr - rd_ptr.
- Push and pop on the same edge:
  - Both take effect and count is unchanged. This includes the full case: the pop frees a slot, so the push is accepted.
  - When empty, the push is stored and no pop happens, because rd_valid was 0.
- Full with a push and no pop: the event is dropped, overflow is set to 1, and prev_q/armed still update.
- clr_ovf=1 clears overflow at the edge. If a drop occurs on the same edge, the set wins and overflow=1.
- Reset mid-operation discards all entries; no partial entry is ever read.

Optional Feature:
- Macro: CHANGE_LOGGER_SYNC_EN.
- Defined:
  - sample_in passes through a 2-flop synchronizer, reset to 0, before change detection.
  - Comparison and logged data use the synchronized value, so logged timestamps lag the raw input by 2 cycles.
- Undefined: sample_in is used directly and must be synchronous to clk.

Decomposition:
- Package change_logger_pkg holds:
  - typedef struct packed { logic [DATA_W-1:0] data; logic [TS_W-1:0] ts; } log_entry_t, with the widths taken from package localparams whose defaults are DATA_W=4 and TS_W=16.
  - Pointer-width helper constant.
- One sub-module, logger_fifo: a synchronous FIFO of log_entry_t with push, pop, full, empty and count.
- The top holds ts_q, prev_q/armed, the optional synchronizer, and the overflow logic.

Test Plan:
- Initial value: reset released, en=1, sample_in=4'b0100 held -> exactly one entry {4, ts=0}; count=1.
- Change sequence: sample_in 0100 for 10 cycles, 1100 for 10 cycles, 0011 for 10 cycles, rd_ready=0 -> entries {4,0}, {12,10}, {3,20}; no entries while the value is stable.
- Overflow: DEPTH=8, rd_ready=0, 9 distinct values on consecutive cycles -> count=8 and overflow=1. The 9th value is lost. Then clr_ovf=1 for 1 cycle -> overflow=0.
- Full with simultaneous pop and push: FIFO full, rd_ready=1 and a change on the same edge -> count stays 8, overflow stays 0, and the new entry is at the tail.
- Backpressure and reset: rd_ready toggling -> rd_data/rd_ts stable while stalled. Reset asserted with 5 entries queued -> count=0 and rd_valid=0 at once, without waiting for a clock edge.
- Disable/wrap: en=0 for 5 cycles then 1 with the same value -> re-logged with an unchanged ts. With TS_W=4, after 16 enabled cycles ts wraps to 0.
